fifo_burst_reader: RTL and testbench

//  Consumer on the read side of the team's show-ahead sync FIFO (rddata valid while !empty, pointer advances on rden).

---
 rtl/fifo_burst_reader_pkg.sv | 16 +
 rtl/stream_out_reg.sv | 57 +++++
 rtl/fifo_burst_reader.sv | 132 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
// Holds the hold-register FSM encoding and counter sizing used by the top.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // hold register empty
    S_HOLD = 2'd1,  // beat held, next FIFO word available
    S_WAIT = 2'd2   // beat held, FIFO dry or popping disabled, timer running
  } state_t;

  // Bits needed to count 0..max_val inclusive; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output register of a valid/ready stream: loads one beat, holds it
// unchanged while the sink stalls, and flags acceptance of a last beat.
module stream_out_reg #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              free_o,
  output logic              done_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign free_o  = !valid_q || ready_i;
  assign done_o  = valid_q && ready_i && last_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a show-ahead FIFO, keeps one word in reserve and emits it as a stream
// beat framed into bursts; the reserve lets a short burst close with last set.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_flush,
  output logic              o_fifo_rden,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  input  logic              i_fifo_empty,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_burst_done,
  output logic              o_busy
);

  localparam int CNT_W = cnt_w(BURST_LEN);
  localparam int TMR_W = cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] h_data_q, h_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic h_vld;
  logic fifo_avail;
  logic cnt_hit;
  logic tmr_hit;
  logic release_beat;
  logic last_next;
  logic o_free;
  logic h_move;
  logic pop;

  // The hold register is occupied exactly when the FSM is out of S_IDLE.
  assign h_vld        = (state_q != S_IDLE);
  assign fifo_avail   = i_en && !i_fifo_empty;
  assign cnt_hit      = (cnt_q == CNT_LAST);
  assign tmr_hit      = (tmr_q == TMR_LAST);
  assign last_next    = cnt_hit || tmr_hit || i_flush;
  assign release_beat = fifo_avail || last_next;
  assign h_move       = h_vld && o_free && release_beat;

  // Gated by rst so the FIFO sees no pop while the reader is held in reset.
  assign pop          = !rst && fifo_avail && (!h_vld || h_move);
  assign o_fifo_rden  = pop;

  always_comb begin
    state_d  = state_q;
    h_data_d = h_data_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;

    if (pop) begin
      h_data_d = i_fifo_rddata;
    end

    if (h_move) begin
      cnt_d = last_next ? '0 : cnt_q + CNT_W'(1);
    end

    if (pop || h_move) begin
      tmr_d = '0;
    end else if (h_vld && !tmr_hit) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_HOLD;
      end
      S_HOLD, S_WAIT: begin
        if (pop) begin
          state_d = S_HOLD;
        end else if (h_move) begin
          state_d = S_IDLE;
        end else if (fifo_avail) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  // NOTE: held data is only read while h_vld is set, so it needs no reset.
  always_ff @(posedge clk) begin
    h_data_q <= h_data_d;
  end

  stream_out_reg #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (h_move),
    .data_i  (h_data_q),
    .last_i  (last_next),
    .ready_i (i_ready),
    .valid_o (o_valid),
    .data_o  (o_data),
    .last_o  (o_last),
    .free_o  (o_free),
    .done_o  (o_burst_done)
  );

  assign o_busy = h_vld || o_valid;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: show-ahead FIFO model feeds the reader, a scoreboard
// of expected beats is filled at preload time and drained at stream accept.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_en = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_ready = 1'b1;
  logic          o_fifo_rden;
  logic [DW-1:0] i_fifo_rddata;
  logic          i_fifo_empty;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          o_burst_done;
  logic          o_busy;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t  sb[$];
  int     acc_cyc[$];
  beat_t  mon_b;
  int     cyc = 0;
  int     n_done = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  logic   tgl = 1'b0;

  // Show-ahead FIFO model
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          tb_clr = 1'b0;

  assign i_fifo_empty  = (rd_ptr == wr_ptr);
  assign i_fifo_rddata = i_fifo_empty ? '0 : mem[rd_ptr % 256];

  always @(posedge clk) begin
    if (tb_clr) rd_ptr <= wr_ptr;
    else if (o_fifo_rden) rd_ptr <= rd_ptr + 1;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_burst_reader #(
    .DATA_W    (DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_flush       (i_flush),
    .o_fifo_rden   (o_fifo_rden),
    .i_fifo_rddata (i_fifo_rddata),
    .i_fifo_empty  (i_fifo_empty),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_last        (o_last),
    .o_burst_done  (o_burst_done),
    .o_busy        (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tgl) i_ready = ~i_ready;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    mem[wr_ptr % 256] = d;
    wr_ptr++;
    sb.push_back(beat_t'{last: l, data: d});
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_busy) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_idle", o_busy, 0);
  endtask

  // Stream monitor: compare every presented beat with the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          check("spurious_beat", o_valid, 0);
        end else begin
          check("data", o_data, sb[0].data);
          check("last", o_last, sb[0].last);
          if (i_ready) begin
            check("burst_done", o_burst_done, sb[0].last);
            if (o_burst_done) n_done++;
            mon_b = sb.pop_front();
            acc_cyc.push_back(cyc);
          end else begin
            check("done_stall", o_burst_done, 0);
          end
        end
      end else begin
        check("done_idle", o_burst_done, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_done", o_burst_done, 0);
    check("rst_rden", o_fifo_rden, 0);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_data, 0);
    rst = 1'b0;
    tick();

    // Two full bursts back to back
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i), (i % BL) == BL - 1);
    acc_cyc.delete();
    d0 = n_done;
    i_en = 1'b1;
    drain(40);
    check("t1_beats", acc_cyc.size(), 8);
    if (acc_cyc.size() == 8) check("t1_thruput", acc_cyc[7] - acc_cyc[0], 7);
    check("t1_done_cnt", n_done - d0, 2);

    // Short burst closed by timeout
    i_en = 1'b0;
    push(8'hA0, 1'b0);
    push(8'hA1, 1'b1);
    acc_cyc.delete();
    i_en = 1'b1;
    drain(40);
    check("t2_beats", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("t2_timeout_gap", acc_cyc[1] - acc_cyc[0], TO);

    // Stalling sink, alternating ready
    i_en = 1'b0;
    for (int i = 0; i < 12; i++) push(DW'(8'h30 + i), (i % BL) == BL - 1);
    acc_cyc.delete();
    tgl = 1'b1;
    i_en = 1'b1;
    drain(80);
    tgl = 1'b0;
    i_ready = 1'b1;
    check("t3_beats", acc_cyc.size(), 12);

    // Flush of a held beat, then flush while idle
    push(8'h55, 1'b1);
    repeat (3) tick();
    check("t4_held", o_valid, 0);
    check("t4_busy", o_busy, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("t4_valid", o_valid, 1);
    check("t4_data", o_data, 8'h55);
    check("t4_last", o_last, 1);
    drain(10);
    i_flush = 1'b1;
    repeat (3) tick();
    i_flush = 1'b0;
    check("t4_idle_valid", o_valid, 0);
    check("t4_idle_busy", o_busy, 0);

    // Popping disabled with a held beat and a non-empty FIFO
    i_en = 1'b0;
    push(8'hB0, 1'b1);
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    push(8'hB1, 1'b0);
    push(8'hB2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      check("t6_no_rden", o_fifo_rden, 0);
      tick();
    end
    check("t6_b0_closed", sb.size(), 2);
    i_en = 1'b1;
    drain(40);

    // Asynchronous reset in the middle of a burst
    i_en = 1'b0;
    for (int i = 0; i < 8; i++) push(DW'(8'hC0 + i), (i % BL) == BL - 1);
    acc_cyc.delete();
    i_en = 1'b1;
    n = 0;
    while (acc_cyc.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t5_reached_beat2", acc_cyc.size() >= 2, 1);
    #2;
    sb.delete();
    rst = 1'b1;
    #1;
    check("t5_valid_async", o_valid, 0);
    check("t5_rden_async", o_fifo_rden, 0);
    check("t5_busy_async", o_busy, 0);
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
    tick();
    rst = 1'b0;
    i_en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push(DW'(8'hD0 + i), i == 3);
    acc_cyc.delete();
    i_en = 1'b1;
    drain(30);
    check("t5_beats", acc_cyc.size(), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
